// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the board input debouncer: the per-channel FSM
// state type and the stability-count computation (also used by the
// seven-segment refresh divider).
package input_debouncer_pkg;

   typedef enum logic {
      STABLE = 1'b0,
      PEND   = 1'b1
   } db_state_t;

   localparam int NUM_PBTN  = 6;
   localparam int NUM_SWTCH = 16;
   localparam int SIM_COUNT = 5;

   // Number of consecutive clocks an input must hold before it is accepted.
   function automatic int calc_count(input int clk_freq_hz,
                                     input int period_ms,
                                     input bit simulate);
      return simulate ? SIM_COUNT : (clk_freq_hz / 1000) * period_ms;
   endfunction

endpackage

// File: rtl/input_debouncer_db_channel.sv
// One debounced input: two-flop synchronizer followed by a STABLE/PEND FSM
// with a stability counter. The output only follows the synchronized input
// after it has differed from the output for N consecutive clocks.
module db_channel
   import input_debouncer_pkg::*;
#(
   parameter int   N       = 5,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int             CW       = $clog2(N);
   localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

   logic          s1;
   logic          s2;
   db_state_t     state;
   db_state_t     state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          out_nxt;

   // Synchronizer; resets to the output value so release causes no count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= RST_VAL;
         s2 <= RST_VAL;
      end else begin
         s1 <= din;
         s2 <= s1;
      end
   end

   // State, counter and debounced output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= STABLE;
         cnt   <= '0;
         dout  <= RST_VAL;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         dout  <= out_nxt;
      end
   end

   // Next-state: leave STABLE on any difference, return on bounce or acceptance.
   always_comb begin
      state_nxt = state;
      case (state)
         STABLE:  if (s2 != dout) state_nxt = PEND;
         PEND:    if ((s2 == dout) || (cnt == CNT_LAST)) state_nxt = STABLE;
         default: state_nxt = STABLE;
      endcase
   end

   // Counter and output update; the counter stops at N-1 and never wraps.
   always_comb begin
      cnt_nxt = cnt;
      out_nxt = dout;
      case (state)
         STABLE: begin
            cnt_nxt = (s2 != dout) ? CW'(1) : '0;
         end
         PEND: begin
            if (s2 == dout) begin
               cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
               out_nxt = s2;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: cnt_nxt = '0;
      endcase
   end

endmodule

// File: rtl/input_debouncer.sv
// Debounces and synchronizes the 6 pushbuttons and 16 slide switches.
// Optional feature macro: DEBOUNCE_EDGE_EN adds pbtn_rise, a one-cycle
// pulse after each debounced pushbutton 0->1 transition.
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int         CLK_FREQ_HZ  = 75000000,
   parameter int         DEBOUNCE_MS  = 5,
   parameter int         SIMULATE     = 0,
   parameter logic [5:0] PB_RESET_VAL = 6'b000001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  pbtn_in,
   input  logic [15:0] switch_in,
   output logic [5:0]  pbtn_db,
   output logic [15:0] swtch_db
`ifdef DEBOUNCE_EDGE_EN
   ,
   output logic [5:0]  pbtn_rise
`endif
);

   localparam int N = calc_count(CLK_FREQ_HZ, DEBOUNCE_MS, SIMULATE != 0);

   generate
      for (genvar i = 0; i < NUM_PBTN; i++) begin : g_pbtn
         db_channel #(.N(N), .RST_VAL(PB_RESET_VAL[i])) u_ch (
            .clk  (clk),
            .reset(reset),
            .din  (pbtn_in[i]),
            .dout (pbtn_db[i])
         );
      end
      for (genvar i = 0; i < NUM_SWTCH; i++) begin : g_swtch
         db_channel #(.N(N), .RST_VAL(1'b0)) u_ch (
            .clk  (clk),
            .reset(reset),
            .din  (switch_in[i]),
            .dout (swtch_db[i])
         );
      end
   endgenerate

`ifdef DEBOUNCE_EDGE_EN
   logic [5:0] pbtn_db_q;

   // Previous debounced value; reset matches pbtn_db so release gives no pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pbtn_db_q <= PB_RESET_VAL;
      else        pbtn_db_q <= pbtn_db;
   end

   assign pbtn_rise = pbtn_db & ~pbtn_db_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer at SIMULATE=1 (N=5): directed scenarios
// with literal expectations plus randomized pin activity, all compared
// every cycle against a window-based behavioural model.
module tb_input_debouncer;

   localparam int               NW      = 5;
   localparam logic [21:0]      RST_VEC = {16'h0000, 6'b000001};

   logic        clk;
   logic        reset;
   logic [5:0]  pbtn_in;
   logic [15:0] switch_in;
   logic [5:0]  pbtn_db;
   logic [15:0] swtch_db;
`ifdef DEBOUNCE_EDGE_EN
   logic [5:0]  pbtn_rise;
`endif

   int checks = 0;
   int errors = 0;

   input_debouncer #(
      .CLK_FREQ_HZ (75000000),
      .DEBOUNCE_MS (5),
      .SIMULATE    (1),
      .PB_RESET_VAL(6'b000001)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .pbtn_in  (pbtn_in),
      .switch_in(switch_in),
      .pbtn_db  (pbtn_db),
      .swtch_db (swtch_db)
`ifdef DEBOUNCE_EDGE_EN
      ,
      .pbtn_rise(pbtn_rise)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: a channel flips once its last NW synchronized samples
   // all differ from its current output. Bits 5:0 buttons, 21:6 switches.
   logic [21:0] m_s1   = RST_VEC;
   logic [21:0] m_s2   = RST_VEC;
   logic [21:0] m_out  = RST_VEC;
   logic [21:0] m_prev = RST_VEC;
   logic [5:0]  m_rise = '0;
   logic [21:0] win [NW];

   initial for (int j = 0; j < NW; j++) win[j] = RST_VEC;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s1   = RST_VEC;
         m_s2   = RST_VEC;
         m_out  = RST_VEC;
         m_rise = '0;
         for (int j = 0; j < NW; j++) win[j] = RST_VEC;
      end else begin
         for (int j = NW - 1; j > 0; j--) win[j] = win[j-1];
         win[0] = m_s2;
         m_prev = m_out;
         for (int c = 0; c < 22; c++) begin
            automatic bit all_diff = 1'b1;
            for (int j = 0; j < NW; j++)
               if (win[j][c] == m_prev[c]) all_diff = 1'b0;
            if (all_diff) m_out[c] = ~m_prev[c];
         end
         m_rise = m_out[5:0] & ~m_prev[5:0];
         m_s2   = m_s1;
         m_s1   = {switch_in, pbtn_in};
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      check("model_pbtn_db", 32'(pbtn_db), 32'(m_out[5:0]));
      check("model_swtch_db", 32'(swtch_db), 32'(m_out[21:6]));
`ifdef DEBOUNCE_EDGE_EN
      check("model_pbtn_rise", 32'(pbtn_rise), 32'(m_rise));
`endif
   end

   // Advance n active edges; inputs change 2 time units after the edge.
   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      logic [4:0] b;
      int         r;
      int         d;

      reset     = 1'b0;
      pbtn_in   = 6'b000001;
      switch_in = 16'h0000;

      // Reset values
      ticks(3);
      check("rst_pbtn_db", 32'(pbtn_db), 32'h01);
      check("rst_swtch_db", 32'(swtch_db), 32'h0);
`ifdef DEBOUNCE_EDGE_EN
      check("rst_pbtn_rise", 32'(pbtn_rise), 32'h0);
`endif
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ticks(1);
`ifdef DEBOUNCE_EDGE_EN
         check("release_no_rise", 32'(pbtn_rise), 32'h0);
`endif
      end
      check("release_pbtn_db", 32'(pbtn_db), 32'h01);

      // Clean step on pbtn_in[4]: first tick lands on k0
      pbtn_in[4] = 1'b1;
      ticks(6);
      check("step_k0p5", 32'(pbtn_db[4]), 32'h0);
      ticks(1);
      check("step_k0p6", 32'(pbtn_db[4]), 32'h1);
`ifdef DEBOUNCE_EDGE_EN
      check("step_rise_on", 32'(pbtn_rise), 32'h10);
      ticks(1);
      check("step_rise_off", 32'(pbtn_rise), 32'h0);
`endif

      // Glitch on pbtn_in[1] shorter than N
      pbtn_in[1] = 1'b1;
      ticks(4);
      pbtn_in[1] = 1'b0;
      ticks(12);
      check("glitch_pbtn_db", 32'(pbtn_db), 32'h11);

      // Bounce on switch_in[7]
      switch_in[7] = 1'b1; ticks(2);
      switch_in[7] = 1'b0; ticks(2);
      switch_in[7] = 1'b1; ticks(2);
      switch_in[7] = 1'b0; ticks(2);
      switch_in[7] = 1'b1;
      ticks(6);
      check("bounce_k0p5", 32'(swtch_db), 32'h0);
      ticks(1);
      check("bounce_k0p6", 32'(swtch_db), 32'h80);

      // Release direction on pbtn_in[0]
      pbtn_in[0] = 1'b0;
      ticks(6);
      check("fall_k0p5", 32'(pbtn_db[0]), 32'h1);
      ticks(1);
      check("fall_k0p6", 32'(pbtn_db), 32'h10);
`ifdef DEBOUNCE_EDGE_EN
      check("fall_no_rise", 32'(pbtn_rise), 32'h0);
`endif

      // Reset mid-count
      switch_in = 16'hFFFF;
      ticks(4);
      reset = 1'b0;
      #1;
      check("midrst_swtch_db", 32'(swtch_db), 32'h0);
      check("midrst_pbtn_db", 32'(pbtn_db), 32'h01);
      ticks(2);
      reset = 1'b1;
      ticks(6);
      check("midrst_r5", 32'(swtch_db), 32'h0);
      ticks(1);
      check("midrst_r6", 32'(swtch_db), 32'hFFFF);

      // Randomized activity with occasional asynchronous resets
      for (int i = 0; i < 4000; i++) begin
         ticks(1);
         r = $urandom_range(0, 99);
         if (r < 12) begin
            b = 5'($urandom_range(0, 21));
            if (b < 5'd6) pbtn_in[b[2:0]] = ~pbtn_in[b[2:0]];
            else          switch_in[4'(b - 5'd6)] = ~switch_in[4'(b - 5'd6)];
         end
         if ($urandom_range(0, 399) == 0) begin
            d = $urandom_range(0, 5);
            if (d >= 3) d++;
            #(d);
            reset = 1'b0;
            ticks(2);
            reset = 1'b1;
         end
      end

      ticks(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Debounces and synchronizes the Nexys4 pushbuttons and slide switches before they reach the bot interface and the KCPSM6 I/O ports. It sits directly upstream of the bot interface, on the 75 MHz system clock. Each of the 22 raw board inputs gets a two-flop synchronizer and a per-channel stability counter. An optional one-cycle rising-edge pulse is produced for each pushbutton.

## Interface
Parameters:
- CLK_FREQ_HZ, 75000000, system clock frequency.
- DEBOUNCE_MS, 5, time an input must hold stable before the output follows.
- SIMULATE, 0, when 1 forces the stability count N to 5 cycles.
- PB_RESET_VAL, 6'b000001, reset value of pbtn_db.
  - Bit 0 is the active-low CPU reset button, so its idle value is 1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- pbtn_in, input, 6: raw buttons {btnC, btnL, btnU, btnR, btnD, btnCpuReset}.
- switch_in, input, 16: raw slide switches.
- pbtn_db, output, 6: debounced buttons.
- swtch_db, output, 16: debounced switches.
- pbtn_rise, output, 6: one-cycle rising-edge pulses. Present only with DEBOUNCE_EDGE_EN.

## Operation
- N = SIMULATE ? 5 : CLK_FREQ_HZ/1000*DEBOUNCE_MS, which is 375000 at the defaults.
- Counter width is $clog2(N). N is fixed at elaboration and must be ≥ 2.
- Per channel: s1 → s2 synchronizer, then a two-state FSM.
  - STABLE: s2 == out and cnt == 0. When s2 != out, go to PEND with cnt ← 1.
  - PEND, s2 == out (bounce back): cnt ← 0, go to STABLE. The output is unchanged.
  - PEND, s2 != out and cnt == N−1: out ← s2, cnt ← 0, go to STABLE.
  - PEND, s2 != out and cnt < N−1: cnt ← cnt + 1.
- Both directions (press and release) use the same rule. All channels are independent.
- pbtn_rise[i] is high for exactly the one cycle after the edge where pbtn_db[i] goes 0 → 1.
  - There is no pulse on 1 → 0.
  - There is no pulse on reset release, including bit 0 idling at 1.
- Reset values:
  - pbtn_db = PB_RESET_VAL; swtch_db = 0; pbtn_rise = 0.
  - Every FSM in STABLE, every cnt = 0.
  - s1 and s2 take the same reset value as their channel's output. This prevents a spurious count after reset release.

## Timing
- Let k0 be the first clock edge that samples a new pin level.
  - s2 holds the new level after edge k0+1.
  - With no bounce, out changes at edge k0+N+1, i.e. latency N+1 edges.
  - At SIMULATE=1 this is k0+6.
- Any excursion at s2 lasting fewer than N cycles never reaches the output.
- Bounce restarts the full N-cycle window from the last return to the old level.
- Reset assertion mid-count: all outputs go to their reset values immediately (asynchronous). Pending counts are discarded.
- Reset deassertion: the first edge after release behaves as a normal sample. No output change is possible before edge N+1 after release.
- Simultaneous changes on several channels resolve independently, in the same cycle if they share timing.
- The counter saturates structurally: cnt never exceeds N−1 and never wraps.

## Configuration
- DEBOUNCE_EDGE_EN defined: the pbtn_rise port and its registers exist.
- DEBOUNCE_EDGE_EN undefined: the port is absent and no edge logic is built.
- pbtn_db and swtch_db are identical in both builds.

## Structure
- Shared package: the FSM state typedef {STABLE, PEND}, and the N-computation function/constant shared with the sevensegment refresh divider.
- Sub-module db_channel: one synchronizer, FSM and counter per input. Its parameters are N and RST_VAL.
  - Generated 6 times for buttons and 16 times for switches.
  - The top level contains only generate loops and the optional edge registers.

## Test plan
- Clean step (SIMULATE=1): pbtn_in[4] 0→1 held → pbtn_db[4] rises at edge k0+6; pbtn_rise[4] is high only for the following cycle.
- Bounce: switch_in[7] toggles 1,0,1,0 at 2-cycle intervals, then holds 1 → swtch_db[7] rises exactly 6 edges after the final 0→1 sample. No intermediate change.
- Glitch: pbtn_in[1] high for 4 cycles (< N) → pbtn_db[1] stays 0 and pbtn_rise stays 0.
- Reset mid-count: switch_in = 16'hFFFF; reset asserted low at k0+3 → swtch_db = 0 immediately. After release, swtch_db = 16'hFFFF at release edge + 6.
- Reset values: during reset, pbtn_db = 6'b000001. After release with pbtn_in = 6'b000001, no pbtn_rise pulse appears within 20 cycles.
- Release direction: pbtn_in[0] 1→0 (CPU reset pressed) → pbtn_db[0] falls at k0+6; no rise pulse.
